fifo_rr_arbiter: RTL
====================

// Module: fifo_rr_arbiter
// PURPOSE
//  Round-robin enqueue arbiter that shares one fifo write port between NUM_REQ producers.
//  Sits directly in front of the fifo: consumes its full flag, drives its enq and data_in.
//  Grants one producer at a time, holds the grant for bursts of up to BURST_LEN beats,
//  and never issues an enq while the fifo reports full (the fifo silently drops those).
// PARAMETERS
//  NUM_REQ     4   number of producers, >=2
//  DATA_WIDTH  64  payload width; matches the fifo DATA_WIDTH
//  BURST_LEN   4   max beats per grant, >=1
//  CNT_WIDTH   16  width of each per-producer grant statistic counter
//  ID_WIDTH    localparam = $clog2(NUM_REQ)
// PORTS
//  clk        in   1                   clock, rising edge
//  reset      in   1                   asynchronous, active-low reset
//  req_valid  in   NUM_REQ             producer i has a beat; bit i = producer i
//  req_data   in   NUM_REQ*DATA_WIDTH  producer i payload in slice [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  NUM_REQ             beat of producer i accepted this cycle when valid&ready
//  fifo_full  in   1                   fifo full flag
//  fifo_enq   out  1                   fifo enq strobe
//  fifo_data  out  DATA_WIDTH          fifo data_in
//  grant_id   out  ID_WIDTH            current owner; 0 when idle
//  busy       out  1                   1 while in GRANT state
//  stat_sel   in   ID_WIDTH            producer whose statistic is read
//  stat_cnt   out  CNT_WIDTH           grant count of producer stat_sel
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rr_ptr=0, owner=0, beats=0, all stat counters=0.
//   Reset-state outputs: req_ready=0, fifo_enq=0, fifo_data=0, grant_id=0, busy=0.
//   Reset asserted mid-burst: fifo_enq drops immediately; no partial beat is written.
//  FSM states: IDLE, GRANT (registered state, owner, beats, rr_ptr).
//  IDLE: if any req_valid, owner <= first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//   modulo NUM_REQ; beats <= 0; go GRANT. Otherwise stay in IDLE.
//   No beat transfers in IDLE: one cycle of arbitration latency.
//  GRANT, combinational outputs:
//   req_ready[owner] = !fifo_full; all other req_ready bits 0.
//   fifo_enq = req_valid[owner] & !fifo_full; fifo_data = req_data slice of owner.
//   Outside GRANT, fifo_data = 0.
//  Transfer = fifo_enq==1. On transfer: beats <= beats+1.
//  Release to IDLE (rr_ptr <= owner+1 mod NUM_REQ) when either:
//   (a) a transfer occurs with beats==BURST_LEN-1, or
//   (b) req_valid[owner]==0 (no transfer that cycle).
//  fifo_full==1 with valid held: stay in GRANT, beats unchanged, no timeout.
//  Producer rule: req_data stable while req_valid & !req_ready; dropping valid forfeits the grant.
//  Fairness: a continuously requesting producer waits at most
//   (NUM_REQ-1)*(BURST_LEN+1) non-stalled cycles before it is granted.
//  Simultaneous requests in IDLE: rr_ptr order decides; rr_ptr=0 after reset favours producer 0.
//  rr_ptr wraps NUM_REQ-1 -> 0. beats width = $clog2(BURST_LEN+1).
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//   one CNT_WIDTH counter per producer, +1 on each IDLE->GRANT for that producer.
//   Counters saturate at all-ones and clear only on reset.
//   stat_cnt = counter[stat_sel], combinational.
//  Not defined: no counters are built; stat_cnt tied to 0; stat_sel ignored.
// STRUCTURE
//  Shared package fifo_arb_pkg: FSM state encoding (ST_IDLE=1'b0, ST_GRANT=1'b1).
//  One sub-module: rr_pick (combinational: NUM_REQ-bit valid + rr_ptr -> found flag + index).
//  The fifo itself is instantiated by the parent, not inside this block.
// TESTING
//  1 Single producer 2 valid for 3 beats D0..D2, fifo empty ->
//    grant on cycle 1, enq on cycles 2-4, data D0..D2, then IDLE and rr_ptr=3.
//  2 All 4 valid continuously, BURST_LEN=4 ->
//    owner order 0,1,2,3,0; each owner gets exactly 4 enqs; one idle cycle between grants.
//  3 Owner 1 mid-burst, fifo_full=1 for 5 cycles ->
//    fifo_enq=0 and req_ready=0 throughout; beats held; burst resumes with the same data.
//  4 Owner drops valid after 2 beats ->
//    release to IDLE; next grant goes to the next valid producer after owner; no extra enq.
//  5 Reset pulled low during beat 2 of a burst ->
//    all outputs 0 in the same cycle; after release, first grant goes to producer 0.
//  6 FIFO_ARB_STATS_EN, scenario 2 for 12 grants -> stat_cnt=3 for each stat_sel 0..3;
//    without the macro -> stat_cnt=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo round-robin enqueue arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  int                  cand;
  logic [ID_WIDTH-1:0] cand_idx;

  // Walk from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_WIDTH'(cand);
      if (valid[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers, bursts of up
// to BURST_LEN beats. Define FIFO_ARB_STATS_EN to build per-producer grant counters.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int BURST_LEN  = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_enq,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  input  logic [ID_WIDTH-1:0]           stat_sel,
  output logic [CNT_WIDTH-1:0]          stat_cnt
);

  localparam int BEATS_W = $clog2(BURST_LEN + 1);

  // Handshake: a beat moves when req_valid[i] & req_ready[i]; that is exactly fifo_enq.
  arb_state_e          state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] next_ptr;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [BEATS_W-1:0]  beats;
  logic                pick_found;
  logic                in_grant;
  logic                owner_valid;
  logic                last_beat;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant    = (state == ST_GRANT);
  assign owner_valid = req_valid[owner];
  assign last_beat   = (beats == BEATS_W'(BURST_LEN - 1));
  assign next_ptr    = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  assign busy      = in_grant;
  assign grant_id  = in_grant ? owner : '0;
  assign fifo_enq  = in_grant & owner_valid & ~fifo_full;
  assign fifo_data = in_grant ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    req_ready = '0;
    if (in_grant) req_ready[owner] = ~fifo_full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            beats <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A producer that drops valid gives up the rest of its burst.
          if (!owner_valid) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end else if (fifo_enq) begin
            beats <= beats + 1'b1;
            if (last_beat) begin
              state  <= ST_IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] stat_q [NUM_REQ];

  // Counts IDLE->GRANT transitions per producer, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (state == ST_IDLE && pick_found && stat_q[pick_idx] != '1) begin
      stat_q[pick_idx] <= stat_q[pick_idx] + 1'b1;
    end
  end

  assign stat_cnt = stat_q[stat_sel];
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule
